// File: rtl/lcd_note_pkg.sv
// Shared constants and types for the LCD note display path.
// The scheduler and the LCD timing controller both import this package.
package lcd_note_pkg;

  localparam int NOTE_W     = 7;
  localparam int NUM_CH_DEF = 4;
  localparam int CH_W       = $clog2(NUM_CH_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_LATCH = 2'd2
  } sched_state_e;

  // 480x272 panel timing in pixel clocks / lines
  localparam int LCD_H_ACTIVE = 480;
  localparam int LCD_V_ACTIVE = 272;
  localparam int LCD_H_PERIOD = 531;
  localparam int LCD_V_PERIOD = 288;
  localparam int LCD_V_PULSE  = 10;

endpackage

// File: rtl/note_channel_table.sv
// Per-channel {active, note} storage with note-on/off apply logic.
// Port "cur" sees the table including a write landing this cycle; port "rd" sees stored state.
module note_channel_table
  import lcd_note_pkg::*;
#(
  parameter int  NUM_CH = NUM_CH_DEF,
  localparam int CHW    = $clog2(NUM_CH)
) (
  input  logic              clk_i,
  input  logic              res_n_i,
  input  logic              wr_en_i,
  input  logic [CHW-1:0]    wr_ch_i,
  input  logic              wr_on_i,
  input  logic [NOTE_W-1:0] wr_note_i,
  input  logic [CHW-1:0]    cur_ch_i,
  output logic              cur_active_o,
  input  logic [CHW-1:0]    rd_ch_i,
  output logic              rd_active_o,
  output logic [NOTE_W-1:0] rd_note_o
);

  logic [NUM_CH-1:0]             active_q, active_d;
  logic [NUM_CH-1:0][NOTE_W-1:0] note_q, note_d;

  always_comb begin
    active_d = active_q;
    note_d   = note_q;
    if (wr_en_i) begin
      if (wr_on_i) begin
        active_d[wr_ch_i] = 1'b1;
        note_d[wr_ch_i]   = wr_note_i;
      end else if (note_q[wr_ch_i] == wr_note_i) begin
        // A note-off for a note that was since replaced must not silence the newer one
        active_d[wr_ch_i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      active_q <= '0;
      note_q   <= '0;
    end else begin
      active_q <= active_d;
      note_q   <= note_d;
    end
  end

  assign cur_active_o = active_d[cur_ch_i];
  assign rd_active_o  = active_q[rd_ch_i];
  assign rd_note_o    = note_q[rd_ch_i];

endmodule

// File: rtl/lcd_note_scheduler.sv
// Time-shares the LCD bar-graph note input among MIDI channels, rotating
// round-robin every HOLD_FRAMES frames and committing updates only at VSYNC.
module lcd_note_scheduler
  import lcd_note_pkg::*;
#(
  parameter int  NUM_CH      = NUM_CH_DEF,
  parameter int  HOLD_FRAMES = 8,
  localparam int CHW         = $clog2(NUM_CH)
) (
  input  logic              i_clk,
  input  logic              i_res_n,
  input  logic              i_evt_valid,
  output logic              o_evt_ready,
  input  logic [CHW-1:0]    i_evt_ch,
  input  logic              i_evt_on,
  input  logic [NOTE_W-1:0] i_evt_note,
  input  logic              i_vsync,
  output logic              o_note_en,
  output logic [NOTE_W-1:0] o_note_num,
  output logic [CHW-1:0]    o_cur_ch,
  output logic              o_frame_tick
);

  localparam logic [7:0]   HOLD_LAST = 8'(HOLD_FRAMES - 1);
  localparam logic [CHW:0] K_LAST    = (CHW + 1)'(NUM_CH);

  sched_state_e      state_q, state_d;
  logic              vs_prev_q;
  logic [CHW:0]      k_q, k_d;
  logic [CHW-1:0]    cand_q, cand_d;
  logic              cand_ok_q, cand_ok_d;
  logic [7:0]        hold_q, hold_d;
  logic [CHW-1:0]    cur_q, cur_d;
  logic              en_q, en_d;
  logic [NOTE_W-1:0] num_q, num_d;
  logic              tick_q, tick_d;

  logic              evt_acc;
  logic              frame_edge;
  logic              hold_last;
  logic [CHW-1:0]    scan_ch;
  logic [CHW-1:0]    rd_ch;
  logic              cur_active;
  logic              rd_active;
  logic [NOTE_W-1:0] rd_note;

  assign o_evt_ready = (state_q == ST_IDLE);
  assign evt_acc     = i_evt_valid & o_evt_ready;
  assign frame_edge  = vs_prev_q & ~i_vsync;
  assign hold_last   = (hold_q == HOLD_LAST);
  // Truncation to CHW bits gives the modulo-NUM_CH wrap for free
  assign scan_ch     = cur_q + k_q[CHW-1:0];
  assign rd_ch       = (state_q == ST_LATCH) ? cand_q : scan_ch;

  note_channel_table #(
    .NUM_CH (NUM_CH)
  ) u_table (
    .clk_i        (i_clk),
    .res_n_i      (i_res_n),
    .wr_en_i      (evt_acc),
    .wr_ch_i      (i_evt_ch),
    .wr_on_i      (i_evt_on),
    .wr_note_i    (i_evt_note),
    .cur_ch_i     (cur_q),
    .cur_active_o (cur_active),
    .rd_ch_i      (rd_ch),
    .rd_active_o  (rd_active),
    .rd_note_o    (rd_note)
  );

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    cand_d    = cand_q;
    cand_ok_d = cand_ok_q;
    hold_d    = hold_q;
    cur_d     = cur_q;
    en_d      = en_q;
    num_d     = num_q;
    tick_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_edge) begin
          if (hold_last || !cur_active) begin
            state_d = ST_SCAN;
            k_d     = (CHW + 1)'(1);
          end else begin
            state_d   = ST_LATCH;
            cand_d    = cur_q;
            cand_ok_d = 1'b1;
          end
        end
      end
      ST_SCAN: begin
        if (rd_active) begin
          state_d   = ST_LATCH;
          cand_d    = scan_ch;
          cand_ok_d = 1'b1;
        end else if (k_q == K_LAST) begin
          state_d   = ST_LATCH;
          cand_ok_d = 1'b0;
        end else begin
          k_d = k_q + (CHW + 1)'(1);
        end
      end
      ST_LATCH: begin
        state_d = ST_IDLE;
        tick_d  = 1'b1;
        if (cand_ok_q) begin
          en_d  = 1'b1;
          num_d = rd_note;
          cur_d = cand_q;
          if (cand_q != cur_q || hold_last) hold_d = '0;
          else                              hold_d = hold_q + 8'd1;
        end else begin
          en_d   = 1'b0;
          hold_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      state_q   <= ST_IDLE;
      vs_prev_q <= 1'b0;
      k_q       <= '0;
      cand_q    <= '0;
      cand_ok_q <= 1'b0;
      hold_q    <= '0;
      cur_q     <= '0;
      en_q      <= 1'b0;
      num_q     <= '0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vs_prev_q <= i_vsync;
      k_q       <= k_d;
      cand_q    <= cand_d;
      cand_ok_q <= cand_ok_d;
      hold_q    <= hold_d;
      cur_q     <= cur_d;
      en_q      <= en_d;
      num_q     <= num_d;
      tick_q    <= tick_d;
    end
  end

  assign o_note_en    = en_q;
  assign o_note_num   = num_q;
  assign o_cur_ch     = cur_q;
  assign o_frame_tick = tick_q;

endmodule

// File: tb/tb_lcd_note_scheduler.sv
// Scoreboard bench for lcd_note_scheduler: a reference model predicts each
// frame commit at the VSYNC fall, and the tick monitor compares it on arrival.
module tb_lcd_note_scheduler;

  localparam int NUM_CH = 4;
  localparam int HOLD   = 8;

  typedef struct {
    logic       en;
    logic [6:0] num;
    logic [1:0] ch;
    int         lat;
    int         c0;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_ch;
  logic       evt_on;
  logic [6:0] evt_note;
  logic       vsync;
  logic       note_en;
  logic [6:0] note_num;
  logic [1:0] cur_ch;
  logic       frame_tick;

  always #5 clk = ~clk;

  lcd_note_scheduler #(
    .NUM_CH      (NUM_CH),
    .HOLD_FRAMES (HOLD)
  ) dut (
    .i_clk        (clk),
    .i_res_n      (rst_n),
    .i_evt_valid  (evt_valid),
    .o_evt_ready  (evt_ready),
    .i_evt_ch     (evt_ch),
    .i_evt_on     (evt_on),
    .i_evt_note   (evt_note),
    .i_vsync      (vsync),
    .o_note_en    (note_en),
    .o_note_num   (note_num),
    .o_cur_ch     (cur_ch),
    .o_frame_tick (frame_tick)
  );

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t mon_e;

  logic       m_act [NUM_CH];
  logic [6:0] m_note[NUM_CH];
  int         m_cur, m_hold;
  logic       m_en;
  logic [6:0] m_num;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_act[i]  = 1'b0;
      m_note[i] = '0;
    end
    m_cur  = 0;
    m_hold = 0;
    m_en   = 1'b0;
    m_num  = '0;
  endtask

  task automatic m_apply(input int ch, input logic on, input logic [6:0] note);
    if (on) begin
      m_act[ch]  = 1'b1;
      m_note[ch] = note;
    end else if (m_note[ch] == note) begin
      m_act[ch] = 1'b0;
    end
  endtask

  // Predicts the commit for a frame edge driven at the current cycle
  task automatic m_frame(output exp_t e);
    logic adv, found;
    int   cand, k;
    adv   = (m_hold == HOLD - 1) || !m_act[m_cur];
    found = 1'b0;
    cand  = m_cur;
    k     = 0;
    if (!adv) begin
      found = 1'b1;
    end else begin
      for (int j = 1; j <= NUM_CH; j++) begin
        k = j;
        if (m_act[(m_cur + j) % NUM_CH]) begin
          found = 1'b1;
          cand  = (m_cur + j) % NUM_CH;
          break;
        end
      end
    end
    if (found) begin
      m_en  = 1'b1;
      m_num = m_note[cand];
      if (cand != m_cur || m_hold == HOLD - 1) m_hold = 0;
      else                                     m_hold = m_hold + 1;
      m_cur = cand;
    end else begin
      m_en   = 1'b0;
      m_hold = 0;
    end
    e.en  = m_en;
    e.num = m_num;
    e.ch  = 2'(m_cur);
    e.lat = adv ? 2 + k : 2;
    e.c0  = cyc;
  endtask

  always @(negedge clk) begin
    if (rst_n && frame_tick) begin
      if (sb.size() == 0) begin
        check_val("spurious_tick", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check_val("note_en",  note_en,        mon_e.en);
        check_val("note_num", note_num,       mon_e.num);
        check_val("cur_ch",   cur_ch,         mon_e.ch);
        check_val("latency",  cyc - mon_e.c0, mon_e.lat);
      end
    end
  end

  task automatic finish_frame(input int low_left);
    repeat (low_left) @(posedge clk);
    #1 vsync = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic frame();
    exp_t e;
    @(posedge clk);
    #1 vsync = 1'b0;
    m_frame(e);
    sb.push_back(e);
    finish_frame(10);
  endtask

  task automatic send_evt(input int ch, input logic on, input logic [6:0] note);
    int t;
    @(posedge clk);
    #1;
    evt_valid = 1'b1;
    evt_ch    = 2'(ch);
    evt_on    = on;
    evt_note  = note;
    t = 0;
    @(negedge clk);
    while (!evt_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!evt_ready) check_val("evt_accept_timeout", 0, 1);
    else            m_apply(ch, on, note);
    @(posedge clk);
    #1 evt_valid = 1'b0;
  endtask

  task automatic frame_with_edge_evt(input int ch, input logic on, input logic [6:0] note);
    exp_t e;
    @(posedge clk);
    #1;
    vsync     = 1'b0;
    evt_valid = 1'b1;
    evt_ch    = 2'(ch);
    evt_on    = on;
    evt_note  = note;
    @(negedge clk);
    check_val("edge_cycle_ready", evt_ready, 1);
    m_apply(ch, on, note);
    m_frame(e);
    sb.push_back(e);
    @(posedge clk);
    #1 evt_valid = 1'b0;
    finish_frame(9);
  endtask

  task automatic frame_with_busy_evt(input int ch, input logic on, input logic [6:0] note);
    exp_t e;
    int   busy;
    @(posedge clk);
    #1 vsync = 1'b0;
    m_frame(e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    evt_valid = 1'b1;
    evt_ch    = 2'(ch);
    evt_on    = on;
    evt_note  = note;
    busy = 0;
    @(negedge clk);
    while (!evt_ready && busy < 50) begin
      busy++;
      @(negedge clk);
    end
    check_val("busy_not_ready_cycles", busy, e.lat - 1);
    check_val("ready_after_busy", evt_ready, 1);
    m_apply(ch, on, note);
    @(posedge clk);
    #1 evt_valid = 1'b0;
    finish_frame(8);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    rst_n     = 1'b0;
    evt_valid = 1'b0;
    evt_ch    = '0;
    evt_on    = 1'b0;
    evt_note  = '0;
    vsync     = 1'b1;
    m_reset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_note_en",    note_en,    0);
    check_val("rst_note_num",   note_num,   0);
    check_val("rst_cur_ch",     cur_ch,     0);
    check_val("rst_frame_tick", frame_tick, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_val("ready_after_rst", evt_ready, 1);

    // Empty table: three frames, each commits "nothing to show"
    repeat (3) frame();

    // Mid-frame note-on must not reach the display before the next frame
    send_evt(1, 1'b1, 7'd60);
    repeat (3) begin
      @(negedge clk);
      check_val("no_midframe_update", note_en, 0);
    end
    frame();

    // ch0/ch2 alternate, skipping inactive ch1/ch3
    send_evt(1, 1'b0, 7'd60);
    send_evt(0, 1'b1, 7'd48);
    send_evt(2, 1'b1, 7'd72);
    repeat (20) frame();

    // Wrong-note off is ignored; matching off forces immediate rotation
    for (int i = 0; i < 20 && !(m_cur == 2 && m_en); i++) frame();
    send_evt(2, 1'b0, 7'd71);
    frame();
    send_evt(2, 1'b0, 7'd72);
    frame();
    frame();

    // Event on the VSYNC edge cycle is visible in that same frame
    send_evt(0, 1'b0, 7'd48);
    frame();
    frame_with_edge_evt(3, 1'b1, 7'd100);
    frame();

    // Valid held through SCAN/LATCH is accepted once back in IDLE
    send_evt(3, 1'b0, 7'd100);
    send_evt(1, 1'b1, 7'd33);
    frame_with_busy_evt(2, 1'b1, 7'd90);
    frame();
    frame();

    // Reset in the middle of a scan clears all outputs at once
    send_evt(1, 1'b0, 7'd33);
    send_evt(2, 1'b0, 7'd90);
    @(posedge clk);
    #1 vsync = 1'b0;
    m_frame(e);
    sb.push_back(e);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("midscan_rst_note_en",    note_en,    0);
    check_val("midscan_rst_note_num",   note_num,   0);
    check_val("midscan_rst_cur_ch",     cur_ch,     0);
    check_val("midscan_rst_frame_tick", frame_tick, 0);
    sb.delete();
    m_reset();
    @(posedge clk);
    #1 vsync = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_val("ready_after_midscan_rst", evt_ready, 1);
    frame();
    send_evt(3, 1'b1, 7'd5);
    frame();

    repeat (20) @(posedge clk);
    check_val("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
